vip_matrix_win_ctrl: RTL

VIP_MATRIX_WIN_CTRL -- requirements
Module: vip_matrix_win_ctrl

---
 rtl/vip_matrix_win_ctrl.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/vip_matrix_win_ctrl.sv
// -----------------------------------------------------------------------------
// vip_matrix_win_ctrl
//
// Purpose:
//   Control and bookkeeping for a 3x3 matrix (window) generator. It tracks the
//   pixel column and line row of the incoming video stream and runs a small
//   frame FSM (IDLE, PRIME, ACTIVE, DONE). It flags every cycle on which the
//   matrix generator's output holds a complete 3x3 window, and reports that
//   window's centre coordinates. The flag and coordinates pass through a
//   LAT-stage delay line so that they line up with the generator's own
//   latency.
//
// Parameters:
//   IMG_HDISP : active pixels per line
//   IMG_VDISP : active lines per frame
//   LAT       : matrix-generator latency in cycles (1..8)
//
// Ports:
//   clk             in   pixel clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   pre_frame_vsync in   frame sync (same signal fed to the matrix generator)
//   pre_frame_href  in   line valid
//   pre_frame_clken in   pixel enable
//   win_valid       out  current matrix output is a complete 3x3 window
//   win_cx          out  window centre column (13 bit)
//   win_cy          out  window centre row (13 bit)
//   frame_done      out  one-cycle pulse when a full frame has been received
//   frame_abort     out  one-cycle pulse when a frame restarts before finishing
//   ctrl_state      out  FSM state: 0 IDLE, 1 PRIME, 2 ACTIVE, 3 DONE
//   line_err        out  (LINE_CHECK_EN only) sticky line-length error flag
//
// Configuration:
//   Define LINE_CHECK_EN to add the line_err output and the line-length check.
//   Without it there is no line_err port and no comparison logic.
// -----------------------------------------------------------------------------
module vip_matrix_win_ctrl #(
  parameter logic [12:0] IMG_HDISP = 13'd640,
  parameter logic [12:0] IMG_VDISP = 13'd480,
  parameter int          LAT       = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pre_frame_vsync,
  input  logic        pre_frame_href,
  input  logic        pre_frame_clken,
  output logic        win_valid,
  output logic [12:0] win_cx,
  output logic [12:0] win_cy,
  output logic        frame_done,
  output logic        frame_abort,
  output logic [1:0]  ctrl_state
`ifdef LINE_CHECK_EN
  ,
  output logic        line_err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [12:0] CNT_MAX = 13'h1FFF;

  state_t      state_q, state_d;
  logic        vs_q, vs_d;
  logic        armed_q, armed_d;
  logic        href_q, href_d;
  logic [12:0] col_q, col_d;
  logic [12:0] row_q, row_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;

  logic        vld_sr_q [LAT];
  logic        vld_sr_d [LAT];
  logic [12:0] cx_sr_q  [LAT];
  logic [12:0] cx_sr_d  [LAT];
  logic [12:0] cy_sr_q  [LAT];
  logic [12:0] cy_sr_d  [LAT];

  logic        vs_rise;
  logic        href_fall;
  logic        in_frame;
  logic        pix;
  logic        raw_valid;
  logic [12:0] raw_cx;
  logic [12:0] raw_cy;

`ifdef LINE_CHECK_EN
  logic        line_err_q, line_err_d;
`endif

  // Edge detection on the incoming sync signals.
  // A frame start only counts once vsync has been seen low at least once
  // since reset. That way a vsync that is already high when reset is
  // released is not mistaken for a fresh frame start.
  always_comb begin
    vs_d      = pre_frame_vsync;
    href_d    = pre_frame_href;
    armed_d   = armed_q | ~pre_frame_vsync;
    vs_rise   = pre_frame_vsync & ~vs_q & armed_q;
    href_fall = href_q & ~pre_frame_href;
    pix       = pre_frame_href & pre_frame_clken;
    in_frame  = (state_q == ST_PRIME) || (state_q == ST_ACTIVE);
  end

  // Frame FSM and the column/row counters.
  // Counters only move while a frame is being collected (PRIME or ACTIVE).
  // Both saturate instead of wrapping. The FSM decides on the counter's next
  // value, so the state changes on the same edge at which the row reaches its
  // threshold. A new vsync edge in the middle of a frame restarts the frame
  // in PRIME and raises the abort pulse.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    abort_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (vs_rise) begin
          col_d   = '0;
          row_d   = '0;
          state_d = ST_PRIME;
        end
      end
      ST_PRIME, ST_ACTIVE: begin
        if (vs_rise) begin
          col_d   = '0;
          row_d   = '0;
          abort_d = 1'b1;
          state_d = ST_PRIME;
        end else begin
          if (href_fall) begin
            col_d = '0;
            if (row_q != CNT_MAX) begin
              row_d = row_q + 13'd1;
            end
          end else if (pix && (col_q != CNT_MAX)) begin
            col_d = col_q + 13'd1;
          end
          if (row_d == IMG_VDISP) begin
            state_d = ST_DONE;
          end else if ((state_q == ST_PRIME) && (row_d == 13'd2)) begin
            state_d = ST_ACTIVE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    done_d = (state_d == ST_DONE);
  end

  // Raw window qualification.
  // The window centred one column and one row back from the current pixel is
  // complete once two full lines and two pixels of the current line have
  // already arrived. The comparison uses the pre-increment column and row.
  always_comb begin
    raw_valid = (state_q == ST_ACTIVE) && pix && (col_q >= 13'd2);
    raw_cx    = col_q - 13'd1;
    raw_cy    = row_q - 13'd1;
  end

  // Delay line that matches the matrix generator latency.
  // Stage 0 captures the raw qualification and stage LAT-1 drives the
  // outputs, so a window flag appears LAT cycles after its input pixel.
  always_comb begin
    vld_sr_d[0] = raw_valid;
    cx_sr_d[0]  = raw_cx;
    cy_sr_d[0]  = raw_cy;
    for (int i = 1; i < LAT; i++) begin
      vld_sr_d[i] = vld_sr_q[i-1];
      cx_sr_d[i]  = cx_sr_q[i-1];
      cy_sr_d[i]  = cy_sr_q[i-1];
    end
  end

`ifdef LINE_CHECK_EN
  // Sticky line-length check.
  // The column count is sampled when a line ends inside a frame. A new frame
  // start clears the flag, and that clear wins over a simultaneous error.
  always_comb begin
    line_err_d = line_err_q;
    if (vs_rise) begin
      line_err_d = 1'b0;
    end else if (in_frame && href_fall && (col_q != IMG_HDISP)) begin
      line_err_d = 1'b1;
    end
  end
`endif

  // All state registers live here. The asynchronous reset returns everything
  // to zero, including the vsync edge register and the arming flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vs_q    <= 1'b0;
      armed_q <= 1'b0;
      href_q  <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      for (int i = 0; i < LAT; i++) begin
        vld_sr_q[i] <= 1'b0;
        cx_sr_q[i]  <= '0;
        cy_sr_q[i]  <= '0;
      end
`ifdef LINE_CHECK_EN
      line_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      vs_q    <= vs_d;
      armed_q <= armed_d;
      href_q  <= href_d;
      col_q   <= col_d;
      row_q   <= row_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      for (int i = 0; i < LAT; i++) begin
        vld_sr_q[i] <= vld_sr_d[i];
        cx_sr_q[i]  <= cx_sr_d[i];
        cy_sr_q[i]  <= cy_sr_d[i];
      end
`ifdef LINE_CHECK_EN
      line_err_q <= line_err_d;
`endif
    end
  end

  // Every output comes straight from a flop.
  always_comb begin
    win_valid   = vld_sr_q[LAT-1];
    win_cx      = cx_sr_q[LAT-1];
    win_cy      = cy_sr_q[LAT-1];
    frame_done  = done_q;
    frame_abort = abort_q;
    ctrl_state  = state_q;
`ifdef LINE_CHECK_EN
    line_err    = line_err_q;
`endif
  end

endmodule
